// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and entry record for the reorder buffer.
// Every ROB file imports this package so that all of them use the same widths.
package reorder_buffer_pkg;

  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE   = 8;
  localparam int RB_INDEX  = 4;
  localparam int REG_INDEX = 5;
  localparam int FU_NUM    = 4;

  localparam logic [RB_INDEX-1:0] NULL  = 4'hE;
  localparam logic [RB_INDEX-1:0] READY = 4'hF;

  localparam int PTR_W = $clog2(RB_SIZE);
  localparam int CNT_W = $clog2(RB_SIZE + 1);

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [REG_INDEX-1:0] dest;
    logic [WORD_SIZE-1:0] value;
  } robEntry_t;

  // Head and tail wrap explicitly, so RB_SIZE does not have to be a power of two.
  function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RB_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_wb_select.sv
// Per-entry writeback selection over the FU result buses.
// When several FUs name the same entry, the lowest-numbered FU wins.
module rob_wb_select
  import reorder_buffer_pkg::*;
(
  input  logic [FU_NUM*WORD_SIZE-1:0]  data_bus_i,
  input  logic [FU_NUM-1:0]            valid_bus_i,
  input  logic [FU_NUM*RB_INDEX-1:0]   index_bus_i,
  input  logic [RB_SIZE-1:0]           busy_i,
  input  logic [RB_SIZE-1:0]           done_i,
  output logic [RB_SIZE-1:0]           we_o,
  output logic [RB_SIZE*WORD_SIZE-1:0] wdata_o
);

  // The scan runs from the highest FU down, so a lower FU overrides a higher one.
  always_comb begin
    we_o    = '0;
    wdata_o = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      for (int f = FU_NUM - 1; f >= 0; f--) begin
        if (valid_bus_i[f] && (index_bus_i[f*RB_INDEX +: RB_INDEX] == RB_INDEX'(i))) begin
          we_o[i] = busy_i[i] & ~done_i[i];
          wdata_o[i*WORD_SIZE +: WORD_SIZE] = data_bus_i[f*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. It allocates entries at the tail, captures FU
// results, broadcasts finished values on the CDB and retires entries from the head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_reg,
  output logic                          alloc_ready,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic                          commit_valid,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data,
  output logic [RB_INDEX-1:0]           commit_index
);

  robEntry_t            entry_q [RB_SIZE];
  robEntry_t            entry_d [RB_SIZE];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 commit_valid_q;
  logic [REG_INDEX-1:0] commit_reg_q;
  logic [WORD_SIZE-1:0] commit_data_q;
  logic [RB_INDEX-1:0]  commit_index_q;

  logic [RB_SIZE-1:0]           busyVec, doneVec, wbWe;
  logic [RB_SIZE*WORD_SIZE-1:0] wbData;
  logic                         commitFire, allocFire;

  assign alloc_ready  = (count_q != CNT_W'(RB_SIZE));
  assign alloc_index  = RB_INDEX'(tail_q);
  assign commit_valid = commit_valid_q;
  assign commit_reg   = commit_reg_q;
  assign commit_data  = commit_data_q;
  assign commit_index = commit_index_q;
  assign commitFire   = entry_q[head_q].busy && entry_q[head_q].done;
  assign allocFire    = alloc_req && alloc_ready;

  always_comb begin
    busyVec        = '0;
    doneVec        = '0;
    CDB_data_valid = '0;
    CDB_data_data  = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      busyVec[i]        = entry_q[i].busy;
      doneVec[i]        = entry_q[i].done;
      CDB_data_valid[i] = entry_q[i].busy & entry_q[i].done;
      CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = entry_q[i].value;
    end
  end

  rob_wb_select u_wb_select (
    .data_bus_i  (data_bus),
    .valid_bus_i (valid_bus),
    .index_bus_i (RB_index_bus),
    .busy_i      (busyVec),
    .done_i      (doneVec),
    .we_o        (wbWe),
    .wdata_o     (wbData)
  );

  // Writeback only reaches busy, not-done entries. The head retires only if it was done
  // before this edge, and a free tail slot is never busy, so the three updates never collide.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < RB_SIZE; i++) begin
      if (wbWe[i]) begin
        entry_d[i].done  = 1'b1;
        entry_d[i].value = wbData[i*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (commitFire) begin
      entry_d[head_q].busy = 1'b0;
      entry_d[head_q].done = 1'b0;
      head_d = wrapInc(head_q);
    end
    if (allocFire) begin
      entry_d[tail_q].busy = 1'b1;
      entry_d[tail_q].done = 1'b0;
      entry_d[tail_q].dest = alloc_reg;
      tail_d = wrapInc(tail_q);
    end
    case ({allocFire, commitFire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RB_SIZE; i++) entry_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
      commit_index_q <= NULL;
    end else begin
      entry_q        <= entry_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commitFire;
      commit_index_q <= commitFire ? RB_INDEX'(head_q) : NULL;
      if (commitFire) begin
        commit_reg_q  <= entry_q[head_q].dest;
        commit_data_q <= entry_q[head_q].value;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written corner
// sequences, then random traffic compared against a queue-based program-order model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         alloc_req;
  logic [4:0]   alloc_reg;
  logic         alloc_ready;
  logic [3:0]   alloc_index;
  logic [127:0] data_bus;
  logic [3:0]   valid_bus;
  logic [15:0]  RB_index_bus;
  logic [255:0] CDB_data_data;
  logic [7:0]   CDB_data_valid;
  logic         commit_valid;
  logic [4:0]   commit_reg;
  logic [31:0]  commit_data;
  logic [3:0]   commit_index;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_reg      (alloc_reg),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .data_bus       (data_bus),
    .valid_bus      (valid_bus),
    .RB_index_bus   (RB_index_bus),
    .CDB_data_data  (CDB_data_data),
    .CDB_data_valid (CDB_data_valid),
    .commit_valid   (commit_valid),
    .commit_reg     (commit_reg),
    .commit_data    (commit_data),
    .commit_index   (commit_index)
  );

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic driveInputs(input logic aReq, input logic [4:0] aReg, input logic [3:0] vBus,
                             input logic [15:0] idxBus, input logic [127:0] dBus);
    alloc_req    = aReq;
    alloc_reg    = aReg;
    valid_bus    = vBus;
    RB_index_bus = idxBus;
    data_bus     = dBus;
  endtask

  task automatic applyStimulus(input logic aReq, input logic [4:0] aReg, input logic [3:0] vBus,
                               input logic [15:0] idxBus, input logic [127:0] dBus);
    @(negedge clk);
    driveInputs(aReq, aReg, vBus, idxBus, dBus);
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    driveInputs(1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic expReady, input logic [3:0] expAIdx,
                             input logic [7:0] expCdbV, input logic expCv, input logic [4:0] expCreg,
                             input logic [31:0] expCdata, input logic [3:0] expCidx);
    checkVal({tag, ".alloc_ready"}, 256'(alloc_ready), 256'(expReady));
    checkVal({tag, ".alloc_index"}, 256'(alloc_index), 256'(expAIdx));
    checkVal({tag, ".cdb_valid"}, 256'(CDB_data_valid), 256'(expCdbV));
    checkVal({tag, ".commit_valid"}, 256'(commit_valid), 256'(expCv));
    checkVal({tag, ".commit_index"}, 256'(commit_index), 256'(expCidx));
    if (expCv) begin
      checkVal({tag, ".commit_reg"}, 256'(commit_reg), 256'(expCreg));
      checkVal({tag, ".commit_data"}, 256'(commit_data), 256'(expCdata));
    end
  endtask

  // Program-order model: a queue of in-flight instructions, oldest first.
  typedef struct {
    int          idx;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] val;
  } mEnt_t;

  mEnt_t       mq[$];
  int          mTail;
  logic [31:0] mVal [8];
  bit          mCv;
  logic [3:0]  mCidx;
  logic [4:0]  mCreg;
  logic [31:0] mCdata;

  function automatic void modelReset();
    mq.delete();
    mTail  = 0;
    mCv    = 1'b0;
    mCidx  = 4'hE;
    mCreg  = '0;
    mCdata = '0;
    for (int i = 0; i < 8; i++) mVal[i] = '0;
  endfunction

  function automatic void modelStep(input logic aReq, input logic [4:0] aReg, input logic [3:0] vBus,
                                    input logic [15:0] idxBus, input logic [127:0] dBus);
    bit doCommit;
    bit doAlloc;
    int idx;
    mEnt_t e;
    doCommit = (mq.size() > 0) && mq[0].done;
    doAlloc  = aReq && (mq.size() < 8);
    mCv   = doCommit;
    mCidx = doCommit ? 4'(mq[0].idx) : 4'hE;
    if (doCommit) begin
      mCreg  = mq[0].dest;
      mCdata = mq[0].val;
    end
    for (int f = 0; f < 4; f++) begin
      if (vBus[f]) begin
        idx = int'(idxBus[f*4 +: 4]);
        foreach (mq[k]) begin
          if (mq[k].idx == idx && !mq[k].done) begin
            mq[k].done = 1'b1;
            mq[k].val  = dBus[f*32 +: 32];
            mVal[idx]  = dBus[f*32 +: 32];
          end
        end
      end
    end
    if (doCommit) void'(mq.pop_front());
    if (doAlloc) begin
      e.idx  = mTail;
      e.dest = aReg;
      e.done = 1'b0;
      e.val  = '0;
      mq.push_back(e);
      mTail = (mTail + 1) % 8;
    end
  endfunction

  task automatic checkModel(input int cyc);
    logic [7:0]   expV;
    logic [255:0] expD;
    string        tag;
    expV = '0;
    foreach (mq[k]) if (mq[k].done) expV[mq[k].idx] = 1'b1;
    for (int i = 0; i < 8; i++) expD[i*32 +: 32] = mVal[i];
    tag = $sformatf("rand%0d", cyc);
    checkOutput(tag, mq.size() < 8, 4'(mTail), expV, mCv, mCreg, mCdata, mCidx);
    checkVal({tag, ".cdb_data"}, CDB_data_data, expD);
  endtask

  typedef struct {
    logic         aReq;
    logic [4:0]   aReg;
    logic [3:0]   vBus;
    logic [15:0]  idxBus;
    logic [127:0] dBus;
    logic         expReady;
    logic [3:0]   expAIdx;
    logic [7:0]   expCdbV;
    logic         expCv;
    logic [4:0]   expCreg;
    logic [31:0]  expCdata;
    logic [3:0]   expCidx;
  } vec_t;

  vec_t vecs[11];

  initial begin
    reset = 1'b1;
    driveInputs(1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0);

    vecs[0]  = '{1'b1, 5'd3, 4'b0000, 16'hEEEE, 128'd0,                          1'b1, 4'd1, 8'h00, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[1]  = '{1'b0, 5'd0, 4'b0010, 16'hEE0E, {32'd0, 32'd0, 32'd42, 32'd0},   1'b1, 4'd1, 8'h01, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[2]  = '{1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0,                          1'b1, 4'd1, 8'h00, 1'b1, 5'd3, 32'd42, 4'd0};
    vecs[3]  = '{1'b1, 5'd1, 4'b0000, 16'hEEEE, 128'd0,                          1'b1, 4'd2, 8'h00, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[4]  = '{1'b1, 5'd2, 4'b0000, 16'hEEEE, 128'd0,                          1'b1, 4'd3, 8'h00, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[5]  = '{1'b0, 5'd0, 4'b0001, 16'hEEE2, {32'd0, 32'd0, 32'd0, 32'd7},    1'b1, 4'd3, 8'h04, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[6]  = '{1'b0, 5'd0, 4'b1000, 16'hEEEE, {32'd99, 32'd0, 32'd0, 32'd0},   1'b1, 4'd3, 8'h04, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[7]  = '{1'b0, 5'd0, 4'b0100, 16'hE1EE, {32'd0, 32'd5, 32'd0, 32'd0},    1'b1, 4'd3, 8'h06, 1'b0, 5'd0, 32'd0,  4'hE};
    vecs[8]  = '{1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0,                          1'b1, 4'd3, 8'h04, 1'b1, 5'd1, 32'd5,  4'd1};
    vecs[9]  = '{1'b0, 5'd0, 4'b0001, 16'hEEE9, {32'd0, 32'd0, 32'd0, 32'd123},  1'b1, 4'd3, 8'h00, 1'b1, 5'd2, 32'd7,  4'd2};
    vecs[10] = '{1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0,                          1'b1, 4'd3, 8'h00, 1'b0, 5'd0, 32'd0,  4'hE};

    #1;
    checkOutput("reset", 1'b1, 4'd0, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);
    checkVal("reset.cdb_data", CDB_data_data, 256'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic allocate/writeback/commit, out-of-order completion, NULL and out-of-range FUs.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].aReq, vecs[i].aReg, vecs[i].vBus, vecs[i].idxBus, vecs[i].dBus);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expAIdx, vecs[i].expCdbV,
                  vecs[i].expCv, vecs[i].expCreg, vecs[i].expCdata, vecs[i].expCidx);
    end

    // Fill, refused allocations while full, wrap of the tail into the freed slot.
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 5'(i + 4), 4'b0000, 16'hEEEE, 128'd0);
    checkOutput("full", 1'b0, 4'd0, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);
    applyStimulus(1'b1, 5'd31, 4'b0000, 16'hEEEE, 128'd0);
    checkOutput("full.ninth", 1'b0, 4'd0, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);
    applyStimulus(1'b1, 5'd31, 4'b0001, 16'hEEE0, {96'd0, 32'hAA});
    checkOutput("full.wb0", 1'b0, 4'd0, 8'h01, 1'b0, 5'd0, 32'd0, 4'hE);
    applyStimulus(1'b1, 5'd31, 4'b0000, 16'hEEEE, 128'd0);
    checkOutput("full.commit", 1'b1, 4'd0, 8'h00, 1'b1, 5'd4, 32'hAA, 4'd0);
    applyStimulus(1'b1, 5'd9, 4'b0000, 16'hEEEE, 128'd0);
    checkOutput("full.wrap", 1'b0, 4'd1, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);

    // Two FUs on one index: the lower FU's data must stick; a later write is ignored.
    applyStimulus(1'b0, 5'd0, 4'b1011, 16'h2EE2, {32'd20, 32'd0, 32'd55, 32'd10});
    checkVal("prio.cdb_valid", 256'(CDB_data_valid), 256'h04);
    checkVal("prio.data", 256'(CDB_data_data[2*32 +: 32]), 256'd10);
    applyStimulus(1'b0, 5'd0, 4'b1000, 16'h2EEE, {32'd20, 96'd0});
    checkVal("prio.again", 256'(CDB_data_data[2*32 +: 32]), 256'd10);

    // Reset with five entries in flight and the head ready to retire.
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'(i + 1), 4'b0000, 16'hEEEE, 128'd0);
    applyStimulus(1'b0, 5'd0, 4'b0010, 16'hEE0E, {64'd0, 32'd77, 32'd0});
    checkOutput("pre_rst", 1'b1, 4'd5, 8'h01, 1'b0, 5'd0, 32'd0, 4'hE);
    @(negedge clk);
    driveInputs(1'b0, 5'd0, 4'b0000, 16'hEEEE, 128'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst", 1'b1, 4'd0, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);
    @(negedge clk);
    reset = 1'b0;
    idleStep();
    checkOutput("post_rst0", 1'b1, 4'd0, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);
    idleStep();
    checkOutput("post_rst1", 1'b1, 4'd0, 8'h00, 1'b0, 5'd0, 32'd0, 4'hE);

    // Random traffic against the program-order model.
    applyReset();
    modelReset();
    for (int c = 0; c < 400; c++) begin
      logic         aReq;
      logic [4:0]   aReg;
      logic [3:0]   vBus;
      logic [15:0]  idxBus;
      logic [127:0] dBus;
      int           r;
      aReq = ($urandom_range(0, 9) < 5);
      aReg = 5'($urandom);
      for (int f = 0; f < 4; f++) begin
        vBus[f] = ($urandom_range(0, 9) < 4);
        r = $urandom_range(0, 11);
        idxBus[f*4 +: 4] = (r == 10) ? 4'hE : (r == 11) ? 4'hF : 4'(r);
        dBus[f*32 +: 32] = $urandom;
      end
      @(negedge clk);
      driveInputs(aReq, aReg, vBus, idxBus, dBus);
      modelStep(aReq, aReg, vBus, idxBus, dBus);
      @(posedge clk);
      #1;
      checkModel(c);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
